// File: rtl/i2c_sensor_pkg.sv
// Shared definitions for the I2C sensor register file.
//   state_t      : transaction-level FSM states
//   REG_*        : register map (reg 0 is the read-only live temperature)
//   byte_sel     : picks byte idx of a register word, byte 0 = MSB
package i2c_sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_POINTER,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    localparam int REG_TEMP   = 0;
    localparam int REG_CONFIG = 1;
    localparam int REG_TLOW   = 2;
    localparam int REG_THIGH  = 3;

    // Widest register word byte_sel accepts (NBYTES up to 8).
    localparam int MAX_REG_BITS = 64;

    // Byte 0 is the most significant byte of an nbytes-wide word.
    function automatic logic [7:0] byte_sel(input logic [MAX_REG_BITS-1:0] word,
                                            input int nbytes,
                                            input int idx);
        byte_sel = word[(nbytes-1-idx)*8 +: 8];
    endfunction

endpackage

// File: rtl/i2c_address_matcher.sv
// Combinational slave-address matcher.
//   addr      : address requested by the master
//   addr_list : own addresses, entry i at [i*ADDRESSLENGTH +: ADDRESSLENGTH]
//   match     : any entry equals addr
//   index     : lowest matching entry (0 when no match)
module i2c_address_matcher #(
    parameter int ADDRESSLENGTH = 7,
    parameter int ADDRESSNUM    = 2,
    localparam int AIW = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1
) (
    input  logic [ADDRESSLENGTH-1:0]            addr,
    input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] addr_list,
    output logic                                match,
    output logic [AIW-1:0]                      index
);

    // Scan from the top so the lowest matching entry is the last one written.
    always_comb begin
        match = 1'b0;
        index = '0;
        for (int i = ADDRESSNUM-1; i >= 0; i--) begin
            if (addr_list[i*ADDRESSLENGTH +: ADDRESSLENGTH] == addr) begin
                match = 1'b1;
                index = AIW'(i);
            end
        end
    end

endmodule

// File: rtl/i2c_sensor_register_file.sv
// I2C slave register file for a temperature sensor. Sits behind the I2C
// bit/byte engine: a pointer byte selects one of NREGS registers, data bytes
// (MSB first) are staged and committed atomically, reads come from a
// snapshot so one register is never torn across bytes.
//   Clk, Reset        : clock, synchronous active-high reset
//   StartCond/StopCond: bus condition pulses
//   AddrValid, DirectionBuffer, RorW, AddressList -> AddressFound, AddressIndex
//   ByteStrobe, InputBuffer -> ByteAck, ByteNack (one cycle later)
//   OutputBuffer      : next byte for the master to read
//   SensorData        : live temperature (register 0)
//   Pointer           : current register pointer
//   RegFileOut        : registers flattened, slot 0 reads 0
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | bus free or after STOP
// ST_ADDR    | START seen, waiting for address byte
// ST_POINTER | addressed for write, next byte is the pointer
// ST_WDATA   | writing data bytes into staged buffer
// ST_RDATA   | master reading bytes from the snapshot
// ST_IGNORE  | address did not match, ignore bytes until START/STOP
module i2c_sensor_register_file #(
    parameter int ADDRESSLENGTH = 7,
    parameter int ADDRESSNUM    = 2,
    parameter int NREGS         = 4,
    parameter int NBYTES        = 2,
    parameter int PTRWIDTH      = 2,
    parameter int AUTOINC       = 0,
    parameter logic [8*NBYTES-1:0] REGRESET = '0,
    localparam int AIW = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                StartCond,
    input  logic                                StopCond,
    input  logic                                AddrValid,
    input  logic [ADDRESSLENGTH-1:0]            DirectionBuffer,
    input  logic                                RorW,
    input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList,
    output logic                                AddressFound,
    output logic [AIW-1:0]                      AddressIndex,
    input  logic                                ByteStrobe,
    input  logic [7:0]                          InputBuffer,
    output logic [7:0]                          OutputBuffer,
    output logic                                ByteAck,
    output logic                                ByteNack,
    input  logic [8*NBYTES-1:0]                 SensorData,
    output logic [PTRWIDTH-1:0]                 Pointer,
    output logic [8*NBYTES*NREGS-1:0]           RegFileOut
);

    import i2c_sensor_pkg::*;

    localparam int RW = 8*NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0]       LAST_BYTE = CW'(NBYTES-1);
    localparam logic [PTRWIDTH-1:0] LAST_REG  = PTRWIDTH'(NREGS-1);
    localparam logic [PTRWIDTH-1:0] PTR_TEMP  = PTRWIDTH'(REG_TEMP);

    state_t              state, state_next;
    logic [PTRWIDTH-1:0] pointer, ptr_inc, ptr_after;
    logic [CW-1:0]       byte_cnt;
    logic [RW-1:0]       regs [NREGS];
    logic [7:0]          staged [NBYTES];
    logic [RW-1:0]       shadow, cur_val, next_val, commit_val;
    logic                match;
    logic [AIW-1:0]      match_idx;
    logic                ptr_ok;

    i2c_address_matcher #(
        .ADDRESSLENGTH (ADDRESSLENGTH),
        .ADDRESSNUM    (ADDRESSNUM)
    ) u_matcher (
        .addr      (DirectionBuffer),
        .addr_list (AddressList),
        .match     (match),
        .index     (match_idx)
    );

    assign ptr_inc   = (pointer == LAST_REG) ? '0 : pointer + PTRWIDTH'(1);
    assign ptr_after = (AUTOINC != 0) ? ptr_inc : pointer;
    assign ptr_ok    = int'(InputBuffer) < NREGS;
    assign Pointer   = pointer;

    // cur_val feeds the snapshot at address time; next_val feeds the
    // re-snapshot at the end of a register, after any auto-increment.
    always_comb begin
        cur_val  = SensorData;
        next_val = SensorData;
        for (int k = 1; k < NREGS; k++) begin
            if (pointer == PTRWIDTH'(k))   cur_val  = regs[k];
            if (ptr_after == PTRWIDTH'(k)) next_val = regs[k];
        end
    end

    // Last byte arrives on the commit edge, so it bypasses the staging buffer.
    always_comb begin
        commit_val = '0;
        for (int b = 0; b < NBYTES-1; b++) begin
            commit_val[(NBYTES-1-b)*8 +: 8] = staged[b];
        end
        commit_val[7:0] = InputBuffer;
    end

    always_comb begin
        RegFileOut = '0;
        for (int k = 0; k < NREGS; k++) begin
            RegFileOut[k*RW +: RW] = regs[k];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (StartCond) begin
            state_next = ST_ADDR;
        end else if (StopCond) begin
            state_next = ST_IDLE;
        end else if (AddrValid) begin
            if (state == ST_ADDR) begin
                if (!match)    state_next = ST_IGNORE;
                else if (RorW) state_next = ST_POINTER;
                else           state_next = ST_RDATA;
            end
        end else if (ByteStrobe && state == ST_POINTER) begin
            state_next = ST_WDATA;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pointer      <= '0;
            byte_cnt     <= '0;
            AddressFound <= 1'b0;
            AddressIndex <= '0;
            OutputBuffer <= '0;
            ByteAck      <= 1'b0;
            ByteNack     <= 1'b0;
            shadow       <= '0;
            for (int k = 0; k < NREGS; k++)  regs[k]   <= (k == REG_TEMP) ? '0 : REGRESET;
            for (int b = 0; b < NBYTES; b++) staged[b] <= '0;
        end else begin
            ByteAck  <= 1'b0;
            ByteNack <= 1'b0;
            if (StartCond) begin
                byte_cnt     <= '0;
                AddressFound <= 1'b0;
                for (int b = 0; b < NBYTES; b++) staged[b] <= '0;
            end else if (StopCond) begin
                byte_cnt <= '0;
                for (int b = 0; b < NBYTES; b++) staged[b] <= '0;
            end else if (AddrValid) begin
                if (state == ST_ADDR) begin
                    AddressFound <= match;
                    if (match) begin
                        AddressIndex <= match_idx;
                        if (!RorW) begin
                            shadow       <= cur_val;
                            OutputBuffer <= byte_sel(MAX_REG_BITS'(cur_val), NBYTES, 0);
                            byte_cnt     <= '0;
                        end
                    end
                end
            end else if (ByteStrobe) begin
                case (state)
                    ST_POINTER: begin
                        byte_cnt <= '0;
                        if (ptr_ok) begin
                            pointer <= InputBuffer[PTRWIDTH-1:0];
                            ByteAck <= 1'b1;
                        end else begin
                            ByteNack <= 1'b1;
                        end
                    end
                    ST_WDATA: begin
                        // Register 0 is read-only: bytes are refused but the
                        // byte count and auto-increment still track the bus.
                        if (pointer == PTR_TEMP) begin
                            ByteNack <= 1'b1;
                        end else begin
                            ByteAck          <= 1'b1;
                            staged[byte_cnt] <= InputBuffer;
                        end
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            pointer  <= ptr_after;
                            for (int k = 1; k < NREGS; k++) begin
                                if (pointer == PTRWIDTH'(k)) regs[k] <= commit_val;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                    ST_RDATA: begin
                        ByteAck <= 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt     <= '0;
                            pointer      <= ptr_after;
                            shadow       <= next_val;
                            OutputBuffer <= byte_sel(MAX_REG_BITS'(next_val), NBYTES, 0);
                        end else begin
                            byte_cnt     <= byte_cnt + CW'(1);
                            OutputBuffer <= byte_sel(MAX_REG_BITS'(shadow), NBYTES,
                                                     int'(byte_cnt) + 1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_sensor_register_file.sv
module tb_i2c_sensor_register_file;

    import i2c_sensor_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        StartCond, StopCond, AddrValid, RorW, ByteStrobe;
    logic [6:0]  DirectionBuffer;
    logic [13:0] AddressList;
    logic [7:0]  InputBuffer;
    logic [15:0] sensor_val;

    logic        found0, found1, ack0, ack1, nack0, nack1;
    logic [0:0]  idx0, idx1;
    logic [7:0]  ob0, ob1;
    logic [1:0]  ptr0, ptr1;
    logic [63:0] rf0, rf1;

    i2c_sensor_register_file #(.AUTOINC(0), .REGRESET(16'h5A5A)) dut (
        .Clk(Clk), .Reset(Reset), .StartCond(StartCond), .StopCond(StopCond),
        .AddrValid(AddrValid), .DirectionBuffer(DirectionBuffer), .RorW(RorW),
        .AddressList(AddressList), .AddressFound(found0), .AddressIndex(idx0),
        .ByteStrobe(ByteStrobe), .InputBuffer(InputBuffer), .OutputBuffer(ob0),
        .ByteAck(ack0), .ByteNack(nack0), .SensorData(sensor_val),
        .Pointer(ptr0), .RegFileOut(rf0));

    i2c_sensor_register_file #(.AUTOINC(1), .REGRESET(16'h5A5A)) dut_ai (
        .Clk(Clk), .Reset(Reset), .StartCond(StartCond), .StopCond(StopCond),
        .AddrValid(AddrValid), .DirectionBuffer(DirectionBuffer), .RorW(RorW),
        .AddressList(AddressList), .AddressFound(found1), .AddressIndex(idx1),
        .ByteStrobe(ByteStrobe), .InputBuffer(InputBuffer), .OutputBuffer(ob1),
        .ByteAck(ack1), .ByteNack(nack1), .SensorData(sensor_val),
        .Pointer(ptr1), .RegFileOut(rf1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic st, sp, av, rw, bs;
        logic [6:0] addr;
        logic [7:0] din;
        logic ai;
        logic ea, en;
        logic co; logic [7:0] eo;
        logic cp; logic [1:0] ep;
        logic cf; logic ef; logic ei;
        logic cr; int rk; logic [15:0] er;
    } vec_t;

    typedef struct {
        int   due;
        int   id;
        vec_t v;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic chk_ai = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec%0d actual=%0h required=%0h", nm, id, act, exp);
        end
    endtask

    function automatic vec_t raw(logic st, logic sp, logic av, logic [6:0] a, logic rw,
                                 logic bs, logic [7:0] d);
        vec_t v;
        v.st = st; v.sp = sp; v.av = av; v.addr = a; v.rw = rw; v.bs = bs; v.din = d;
        v.ai = 1'b0; v.ea = 1'b0; v.en = 1'b0;
        v.co = 1'b0; v.eo = '0; v.cp = 1'b0; v.ep = '0;
        v.cf = 1'b0; v.ef = 1'b0; v.ei = 1'b0;
        v.cr = 1'b0; v.rk = 0; v.er = '0;
        return v;
    endfunction

    function automatic vec_t ev_start(); return raw(1, 0, 0, 7'h00, 0, 0, 8'h00); endfunction
    function automatic vec_t ev_stop();  return raw(0, 1, 0, 7'h00, 0, 0, 8'h00); endfunction
    function automatic vec_t ev_idle();  return raw(0, 0, 0, 7'h00, 0, 0, 8'h00); endfunction
    function automatic vec_t ev_addr(logic [6:0] a, logic rw); return raw(0, 0, 1, a, rw, 0, 8'h00); endfunction
    function automatic vec_t ev_byte(logic [7:0] d, logic ea, logic en);
        vec_t v = raw(0, 0, 0, 7'h00, 0, 1, d);
        v.ea = ea; v.en = en;
        return v;
    endfunction
    function automatic vec_t c_ptr(vec_t v, logic [1:0] p); v.cp = 1; v.ep = p; return v; endfunction
    function automatic vec_t c_out(vec_t v, logic [7:0] o); v.co = 1; v.eo = o; return v; endfunction
    function automatic vec_t c_fnd(vec_t v, logic f, logic i); v.cf = 1; v.ef = f; v.ei = i; return v; endfunction
    function automatic vec_t c_reg(vec_t v, int k, logic [15:0] r); v.cr = 1; v.rk = k; v.er = r; return v; endfunction

    task automatic step(input vec_t v, input int id);
        exp_t e;
        StartCond       = v.st;
        StopCond        = v.sp;
        AddrValid       = v.av;
        DirectionBuffer = v.addr;
        RorW            = v.rw;
        ByteStrobe      = v.bs;
        InputBuffer     = v.din;
        e.due  = cyc + 1;
        e.id   = id;
        e.v    = v;
        e.v.ai = chk_ai;
        sb.push_back(e);
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        logic [63:0] rf;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e  = sb.pop_front();
            rf = e.v.ai ? rf1 : rf0;
            chk("ack",  e.id, {63'd0, e.v.ai ? ack1 : ack0},   {63'd0, e.v.ea});
            chk("nack", e.id, {63'd0, e.v.ai ? nack1 : nack0}, {63'd0, e.v.en});
            if (e.v.co) chk("outbuf", e.id, {56'd0, e.v.ai ? ob1 : ob0}, {56'd0, e.v.eo});
            if (e.v.cp) chk("pointer", e.id, {62'd0, e.v.ai ? ptr1 : ptr0}, {62'd0, e.v.ep});
            if (e.v.cf) begin
                chk("found", e.id, {63'd0, e.v.ai ? found1 : found0}, {63'd0, e.v.ef});
                if (e.v.ef) chk("index", e.id, {63'd0, e.v.ai ? idx1 : idx0}, {63'd0, e.v.ei});
            end
            if (e.v.cr) chk("reg", e.id, {48'd0, rf[e.v.rk*16 +: 16]}, {48'd0, e.v.er});
        end
    end

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_found",  0, {63'd0, found0} | {63'd0, found1}, 64'd0);
        chk("rst_index",  0, {63'd0, idx0} | {63'd0, idx1}, 64'd0);
        chk("rst_outbuf", 0, {56'd0, ob0} | {56'd0, ob1}, 64'd0);
        chk("rst_acks",   0, {60'd0, ack0, ack1, nack0, nack1}, 64'd0);
        chk("rst_ptr",    0, {60'd0, ptr0, ptr1}, 64'd0);
        chk("rst_rf",     0, rf0, 64'h5A5A_5A5A_5A5A_0000);
        chk("rst_rf_ai",  0, rf1, 64'h5A5A_5A5A_5A5A_0000);
    endtask

    initial begin
        StartCond = 0; StopCond = 0; AddrValid = 0; RorW = 0; ByteStrobe = 0;
        DirectionBuffer = '0; InputBuffer = '0;
        AddressList = {7'h49, 7'h48};
        sensor_val  = 16'h1234;
        Reset = 1'b1;
        @(negedge Clk);
        do_reset();
        check_reset_state();

        // Write reg1 = ABCD; commit only on second data byte.
        tbl.push_back(c_fnd(ev_start(), 0, 0));
        tbl.push_back(c_fnd(ev_addr(7'h49, 1), 1, 1));
        tbl.push_back(c_ptr(ev_byte(8'h01, 1, 0), 2'd1));
        tbl.push_back(c_reg(ev_byte(8'hAB, 1, 0), REG_CONFIG, 16'h5A5A));
        tbl.push_back(c_reg(ev_byte(8'hCD, 1, 0), REG_CONFIG, 16'hABCD));
        tbl.push_back(ev_stop());
        // Partial write then STOP, partial write then repeated START.
        tbl.push_back(ev_start());
        tbl.push_back(ev_addr(7'h49, 1));
        tbl.push_back(ev_byte(8'h01, 1, 0));
        tbl.push_back(c_reg(ev_byte(8'h11, 1, 0), REG_CONFIG, 16'hABCD));
        tbl.push_back(c_reg(ev_stop(), REG_CONFIG, 16'hABCD));
        tbl.push_back(ev_start());
        tbl.push_back(ev_addr(7'h49, 1));
        tbl.push_back(ev_byte(8'h01, 1, 0));
        tbl.push_back(ev_byte(8'h22, 1, 0));
        tbl.push_back(c_reg(ev_start(), REG_CONFIG, 16'hABCD));
        tbl.push_back(c_fnd(ev_addr(7'h49, 1), 1, 1));
        tbl.push_back(c_ptr(ev_byte(8'h07, 0, 1), 2'd1));
        tbl.push_back(ev_byte(8'h44, 1, 0));
        tbl.push_back(c_reg(ev_byte(8'h55, 1, 0), REG_CONFIG, 16'h4455));
        tbl.push_back(ev_stop());
        // Address miss: bytes neither acked nor nacked.
        tbl.push_back(c_fnd(ev_start(), 0, 0));
        tbl.push_back(c_fnd(ev_addr(7'h4A, 1), 0, 0));
        tbl.push_back(ev_byte(8'h02, 0, 0));
        tbl.push_back(c_ptr(ev_byte(8'h03, 0, 0), 2'd1));
        tbl.push_back(c_ptr(ev_stop(), 2'd1));
        // Data write to read-only reg 0.
        tbl.push_back(ev_start());
        tbl.push_back(c_fnd(ev_addr(7'h48, 1), 1, 0));
        tbl.push_back(c_ptr(ev_byte(8'h00, 1, 0), 2'd0));
        tbl.push_back(ev_byte(8'h99, 0, 1));
        tbl.push_back(c_reg(c_ptr(ev_byte(8'h88, 0, 1), 2'd0), REG_CONFIG, 16'h4455));
        tbl.push_back(c_reg(ev_stop(), REG_TEMP, 16'h0000));
        // Read reg1 with wrap and re-snapshot.
        tbl.push_back(ev_start());
        tbl.push_back(ev_addr(7'h49, 1));
        tbl.push_back(c_ptr(ev_byte(8'h01, 1, 0), 2'd1));
        tbl.push_back(ev_start());
        tbl.push_back(c_fnd(c_out(ev_addr(7'h49, 0), 8'h44), 1, 1));
        tbl.push_back(c_out(ev_byte(8'h00, 1, 0), 8'h55));
        tbl.push_back(c_ptr(c_out(ev_byte(8'h00, 1, 0), 8'h44), 2'd1));
        tbl.push_back(ev_stop());
        // START/STOP with a strobe in the same cycle: strobe ignored.
        tbl.push_back(ev_start());
        tbl.push_back(c_out(ev_addr(7'h49, 0), 8'h44));
        tbl.push_back(raw(1, 0, 0, 7'h00, 0, 1, 8'h00));
        tbl.push_back(c_out(ev_addr(7'h49, 0), 8'h44));
        tbl.push_back(c_out(ev_byte(8'h00, 1, 0), 8'h55));
        tbl.push_back(c_ptr(raw(0, 1, 0, 7'h00, 0, 1, 8'h00), 2'd1));
        tbl.push_back(c_reg(ev_idle(), REG_TLOW, 16'h5A5A));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Temperature snapshot: change SensorData mid-read.
        sensor_val = 16'h1234;
        step(ev_start(), 100);
        step(ev_addr(7'h48, 1), 101);
        step(c_ptr(ev_byte(8'h00, 1, 0), 2'd0), 102);
        step(ev_start(), 103);
        step(c_out(ev_addr(7'h48, 0), 8'h12), 104);
        sensor_val = 16'h5678;
        step(c_out(ev_byte(8'h00, 1, 0), 8'h34), 105);
        step(c_ptr(c_out(ev_byte(8'h00, 1, 0), 8'h56), 2'd0), 106);
        step(ev_stop(), 107);

        // Auto-increment instance from a clean reset.
        do_reset();
        check_reset_state();
        chk_ai = 1'b1;
        sensor_val = 16'h1357;
        step(ev_start(), 200);
        step(c_fnd(ev_addr(7'h49, 1), 1, 1), 201);
        step(c_ptr(ev_byte(8'h03, 1, 0), 2'd3), 202);
        step(ev_byte(8'hA1, 1, 0), 203);
        step(c_reg(c_ptr(ev_byte(8'hA2, 1, 0), 2'd0), REG_THIGH, 16'hA1A2), 204);
        step(ev_byte(8'hB1, 0, 1), 205);
        step(c_ptr(ev_byte(8'hB2, 0, 1), 2'd1), 206);
        step(ev_byte(8'hC1, 1, 0), 207);
        step(c_reg(c_ptr(ev_byte(8'hC2, 1, 0), 2'd2), REG_CONFIG, 16'hC1C2), 208);
        step(c_reg(ev_stop(), REG_TEMP, 16'h0000), 209);
        step(ev_start(), 210);
        step(ev_addr(7'h49, 1), 211);
        step(c_ptr(ev_byte(8'h03, 1, 0), 2'd3), 212);
        step(ev_start(), 213);
        step(c_out(ev_addr(7'h49, 0), 8'hA1), 214);
        step(c_out(ev_byte(8'h00, 1, 0), 8'hA2), 215);
        step(c_ptr(c_out(ev_byte(8'h00, 1, 0), 8'h13), 2'd0), 216);
        step(c_out(ev_byte(8'h00, 1, 0), 8'h57), 217);
        step(c_ptr(c_out(ev_byte(8'h00, 1, 0), 8'hC1), 2'd1), 218);
        step(c_out(ev_byte(8'h00, 1, 0), 8'hC2), 219);
        step(c_reg(ev_stop(), REG_TLOW, 16'h5A5A), 220);
        step(ev_idle(), 221);

        @(negedge Clk);
        #1;
        chk("drain", 999, 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_sensor_register_file.md
Name: i2c_sensor_register_file

Overview:
Clocked, parametrised successor to the I2C slave memory of the TMP10x sensor slave. Supports several slave addresses, a pointer register selecting one of NREGS multi-byte registers, read snapshots, atomic multi-byte writes and optional pointer auto-increment. Sits between the I2C slave bit/byte engine (start/stop detect, shift register) and the sensor core. Register 0 is the read-only live temperature; the others are writable (config, TLOW, THIGH).

Parameters:
ADDRESSLENGTH, 7, slave address width
ADDRESSNUM, 2, number of slave addresses answered, all mapped to the same register file
NREGS, 4, number of registers including read-only reg 0
NBYTES, 2, bytes per register
PTRWIDTH, 2, pointer width, must satisfy 2**PTRWIDTH >= NREGS and PTRWIDTH <= 8
AUTOINC, 0, 1 = pointer increments modulo NREGS after each completed register
REGRESET, 0, reset value of registers 1..NREGS-1 (8*NBYTES bits)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous reset, active-high
StartCond  in  1  one-cycle pulse, START or repeated START seen
StopCond  in  1  one-cycle pulse, STOP seen
AddrValid  in  1  one-cycle pulse, DirectionBuffer and RorW valid
DirectionBuffer  in  ADDRESSLENGTH  address requested by master
RorW  in  1  1 = master writes, 0 = master reads
AddressList  in  ADDRESSLENGTH*ADDRESSNUM  own addresses, entry i at [i*ADDRESSLENGTH +: ADDRESSLENGTH]
AddressFound  out  1  registered address match
AddressIndex  out  max(1,$clog2(ADDRESSNUM))  lowest matching entry
ByteStrobe  in  1  one-cycle pulse per data byte transferred
InputBuffer  in  8  byte written by master, valid with ByteStrobe
OutputBuffer  out  8  next byte for master to read
ByteAck  out  1  one-cycle pulse, byte accepted
ByteNack  out  1  one-cycle pulse, byte refused
SensorData  in  8*NBYTES  live temperature, register 0
Pointer  out  PTRWIDTH  current pointer
RegFileOut  out  8*NBYTES*NREGS  registers 1..NREGS-1 flattened; reg k at [k*8*NBYTES +: 8*NBYTES]; the slot for reg 0 reads 0

Behaviour:
- Reset: state IDLE; Pointer, ByteCounter, AddressFound, AddressIndex, OutputBuffer, ByteAck and ByteNack all 0; registers 1..NREGS-1 set to REGRESET; staged write cleared.
- States: IDLE, ADDR, POINTER, WDATA, RDATA, IGNORE.
- Priority, highest first: Reset, StartCond, StopCond, AddrValid, ByteStrobe.
- StartCond in any state: go to ADDR; ByteCounter 0; AddressFound 0; staged write discarded; Pointer kept.
- StopCond in any state: go to IDLE; ByteCounter 0; staged write discarded; AddressFound kept.
- AddrValid in ADDR: compare DirectionBuffer with every AddressList entry. On a match, AddressFound 1 and AddressIndex set at the next edge. Then go to POINTER if RorW=1; if RorW=0, go to RDATA, snapshot reg[Pointer] (SensorData when Pointer=0) into the read shadow and load its byte 0 into OutputBuffer on the same edge. With no match, go to IGNORE. AddrValid in any other state is ignored.
- ByteAck/ByteNack are registered and appear exactly 1 cycle after ByteStrobe. In IDLE, ADDR and IGNORE neither pulses.
- POINTER, on a strobe: if InputBuffer < NREGS, Pointer <= InputBuffer[PTRWIDTH-1:0] and Ack. Otherwise Nack with Pointer unchanged. Go to WDATA either way; ByteCounter 0.
- WDATA, on a strobe: byte 0 is the MSB. Store InputBuffer into staged[ByteCounter] and Ack. At ByteCounter = NBYTES-1, commit all NBYTES to reg[Pointer] in one edge, wrap ByteCounter to 0, and Pointer++ mod NREGS if AUTOINC. With Pointer=0, bytes are Nacked and never committed, but ByteCounter and AUTOINC still advance.
- RDATA, on a strobe: Ack; ByteCounter++ and OutputBuffer loads the next shadow byte 1 cycle later. After byte NBYTES-1: wrap to 0; Pointer++ if AUTOINC; re-snapshot the new reg[Pointer]; OutputBuffer gets its byte 0.
- Snapshot guarantee: bytes of one register read all come from the same Clk edge, so temperature cannot tear.
- Partial write followed by StopCond or StartCond: the register is unchanged.

Decomposition:
- Shared package i2c_sensor_pkg holds the state enum, the REG_TEMP=0 / REG_CONFIG=1 / REG_TLOW=2 / REG_THIGH=3 constants, and the byte-select function.
- One sub-module, i2c_address_matcher: combinational, parametrised on ADDRESSLENGTH/ADDRESSNUM, returns the match flag and the lowest matching index.

Test Plan:
- Reset=1 for 2 cycles, then observe → all outputs 0, RegFileOut regs 1..3 = REGRESET, Pointer 0.
- AddressList={7'h49,7'h48}; Start, AddrValid addr 7'h49 with RorW=1 → AddressFound=1, AddressIndex=1 next cycle. Repeat with 7'h4A → AddressFound=0 and later strobes produce no Ack/Nack.
- Write pointer 8'h01, then 8'hAB, 8'hCD → three Acks; reg1=16'hABCD only after the 2nd data byte. Same with Stop after 8'hAB → reg1 unchanged.
- Pointer=0, read with SensorData=16'h1234; SensorData changes to 16'h5678 before the 2nd strobe → OutputBuffer 8'h12, then 8'h34.
- Pointer byte 8'h07 with NREGS=4 → Nack, Pointer unchanged. Data write to pointer 0 → Nack, SensorData path unaffected.
- AUTOINC=1, pointer 3, read 3 registers → reg3, reg0, reg1 bytes in order. StartCond and ByteStrobe in the same cycle → strobe ignored, no Ack.
